// File: rtl/alu_share_arbiter_pkg.sv
// Shared request bundle, ALU function encoding and the combinational ALU
// used by every execute-stage unit that borrows the integer datapath.
package alu_share_arbiter_pkg;

    localparam int XLEN    = 32;
    localparam int FUNCT_W = 4;

    typedef logic [XLEN-1:0] int_reg_t;

    typedef enum logic [FUNCT_W-1:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_SLL  = 4'd2,
        FN_SLT  = 4'd3,
        FN_SLTU = 4'd4,
        FN_XOR  = 4'd5,
        FN_SRL  = 4'd6,
        FN_SRA  = 4'd7,
        FN_OR   = 4'd8,
        FN_AND  = 4'd9
    } alu_funct_t;

    typedef struct packed {
        int_reg_t   op1;
        int_reg_t   op2;
        alu_funct_t funct;
    } alu_req_t;

    // Unused encodings deliberately produce zero rather than X.
    function automatic int_reg_t alu_compute(input alu_req_t r);
        int_reg_t   res;
        logic [4:0] shamt;
        shamt = r.op2[4:0];
        case (r.funct)
            FN_ADD:  res = r.op1 + r.op2;
            FN_SUB:  res = r.op1 - r.op2;
            FN_SLL:  res = r.op1 << shamt;
            FN_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(r.op1) < $signed(r.op2))};
            FN_SLTU: res = {{(XLEN-1){1'b0}}, (r.op1 < r.op2)};
            FN_XOR:  res = r.op1 ^ r.op2;
            FN_SRL:  res = r.op1 >> shamt;
            FN_SRA:  res = int_reg_t'($signed(r.op1) >>> shamt);
            FN_OR:   res = r.op1 | r.op2;
            FN_AND:  res = r.op1 & r.op2;
            default: res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// pointer moves past the winner only when the caller strobes advance.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int W = $clog2(N);

    logic [W-1:0] ptr_r;
    logic [W-1:0] ptr_next_s;

    // Scan from the pointer with wrap; first requester found wins.
    always_comb begin : grant_scan
        int   cand;
        logic found;
        logic hit;
        grant     = {N{1'b0}};
        grant_idx = {W{1'b0}};
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand            = int'(ptr_r) + k;
            cand            = (cand >= N) ? (cand - N) : cand;
            hit             = ~found & req[cand];
            grant[cand]     = grant[cand] | hit;
            grant_idx       = hit ? cand[W-1:0] : grant_idx;
            found           = found | hit;
        end
    end

    // Next pointer is one past the winner, wrapping N-1 back to 0.
    always_comb begin
        ptr_next_s = (grant_idx == W'(N-1)) ? {W{1'b0}} : (grant_idx + W'(1));
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {W{1'b0}};
        end else if (advance) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NUM_REQ requesters through a round-robin arbiter, with a
// one-entry output register returning the result, source index and tag.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][XLEN-1:0]          req_op1,
    input  logic [NUM_REQ-1:0][XLEN-1:0]          req_op2,
    input  logic [NUM_REQ-1:0][FUNCT_W-1:0]       req_funct,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]         req_tag,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [XLEN-1:0]                       rsp_result,
    output logic [$clog2(NUM_REQ)-1:0]            rsp_src,
    output logic [TAG_W-1:0]                      rsp_tag
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant_s;
    logic [SRC_W-1:0]   grant_idx_s;
    logic               can_accept_s;
    logic               accept_s;
    alu_req_t           sel_req_s;
    logic [TAG_W-1:0]   sel_tag_s;
    int_reg_t           alu_result_s;

    logic               rsp_valid_r;
    int_reg_t           rsp_result_r;
    logic [SRC_W-1:0]   rsp_src_r;
    logic [TAG_W-1:0]   rsp_tag_r;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (accept_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Flush blocks any accept in the same cycle it empties the slot.
    always_comb begin
        can_accept_s = ~rsp_valid_r | rsp_ready;
        req_ready    = grant_s & {NUM_REQ{can_accept_s & ~flush}};
        accept_s     = |req_ready;
    end

    // One-hot AND-OR mux of the granted request into the single ALU.
    always_comb begin : req_mux
        logic [FUNCT_W-1:0] funct_or;
        sel_req_s.op1 = {XLEN{1'b0}};
        sel_req_s.op2 = {XLEN{1'b0}};
        funct_or      = {FUNCT_W{1'b0}};
        sel_tag_s     = {TAG_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_req_s.op1 = sel_req_s.op1 | (req_op1[i]   & {XLEN{grant_s[i]}});
            sel_req_s.op2 = sel_req_s.op2 | (req_op2[i]   & {XLEN{grant_s[i]}});
            funct_or      = funct_or      | (req_funct[i] & {FUNCT_W{grant_s[i]}});
            sel_tag_s     = sel_tag_s     | (req_tag[i]   & {TAG_W{grant_s[i]}});
        end
        sel_req_s.funct = alu_funct_t'(funct_or);
        alu_result_s    = alu_compute(sel_req_s);
    end

    // Output slot: load on accept (also covers drain+refill), drain on rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= {XLEN{1'b0}};
            rsp_src_r    <= {SRC_W{1'b0}};
            rsp_tag_r    <= {TAG_W{1'b0}};
        end else if (flush) begin
            rsp_valid_r  <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= alu_result_s;
            rsp_src_r    <= grant_idx_s;
            rsp_tag_r    <= sel_tag_s;
        end else if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_src    = rsp_src_r;
    assign rsp_tag    = rsp_tag_r;

endmodule
